// File: rtl/wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_trace_fifo
// Purpose  : Filters CPU debug writeback events (drops r0 writes and
//            non-writes), queues the rest in a show-ahead circular FIFO and
//            presents them one at a time on a valid/ready handshake. Also
//            provides sticky end-of-test and overflow flags plus a count of
//            accepted events.
// Ports    : clk, reset                    - clock, synchronous active-high reset
//            in_pc/in_wen/in_addr/in_wdata - writeback event from the CPU
//            out_valid/out_ready           - head-entry handshake
//            out_pc/out_addr/out_wdata     - head entry fields (0 when empty)
//            count                         - occupied entries
//            event_total                   - events accepted since reset
//            end_seen, overflow            - sticky status flags
// Revision : 1.0 - initial release
// ============================================================================
module wb_trace_fifo #(
   parameter int          DEPTH  = 8,
   parameter logic [31:0] END_PC = 32'h000000a0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              in_pc,
   input  logic                     in_wen,
   input  logic [4:0]               in_addr,
   input  logic [31:0]              in_wdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [4:0]               out_addr,
   output logic [31:0]              out_wdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic [31:0]              event_total,
   output logic                     end_seen,
   output logic                     overflow
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W+1)'(DEPTH);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

   logic [31:0]        r_mem_pc    [DEPTH];
   logic [4:0]         r_mem_addr  [DEPTH];
   logic [31:0]        r_mem_wdata [DEPTH];

   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;
   logic [31:0]        r_event_total;
   logic               r_end_seen;
   logic               r_overflow;

   logic               w_full;
   logic               w_empty;
   logic               w_cap;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;

   assign w_full  = (r_count == c_FULL);
   assign w_empty = (r_count == '0);
   // Capture is gated by the registered end flag, so the END_PC event
   // itself still qualifies.
   assign w_cap   = in_wen && (in_addr != 5'd0) && !r_end_seen;
   assign w_pop   = !w_empty && out_ready;
   // A full FIFO can still take a new entry when the head leaves this cycle.
   assign w_push  = w_cap && (!w_full || w_pop);
   assign w_drop  = w_cap && w_full && !w_pop;

   // Storage needs no reset; stale entries are unreachable through the pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_pc[r_wr_ptr]    <= in_pc;
         r_mem_addr[r_wr_ptr]  <= in_addr;
         r_mem_wdata[r_wr_ptr] <= in_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_event_total <= '0;
         r_end_seen    <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr      <= r_wr_ptr + c_PTR_ONE;
            r_event_total <= r_event_total + 32'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
         if (in_pc == END_PC) begin
            r_end_seen <= 1'b1;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Head fields come straight from storage; zeroed while empty.
   assign out_valid   = !w_empty;
   assign out_pc      = w_empty ? 32'd0 : r_mem_pc[r_rd_ptr];
   assign out_addr    = w_empty ? 5'd0  : r_mem_addr[r_rd_ptr];
   assign out_wdata   = w_empty ? 32'd0 : r_mem_wdata[r_rd_ptr];
   assign count       = r_count;
   assign event_total = r_event_total;
   assign end_seen    = r_end_seen;
   assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_trace_fifo
// Purpose  : Directed self-checking bench for wb_trace_fifo (DEPTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_trace_fifo;

   logic        clk;
   logic        reset;
   logic [31:0] in_pc;
   logic        in_wen;
   logic [4:0]  in_addr;
   logic [31:0] in_wdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [4:0]  out_addr;
   logic [31:0] out_wdata;
   logic [3:0]  count;
   logic [31:0] event_total;
   logic        end_seen;
   logic        overflow;

   int checks   = 0;
   int failures = 0;

   wb_trace_fifo #(.DEPTH(8), .END_PC(32'h000000a0)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_pc       (in_pc),
      .in_wen      (in_wen),
      .in_addr     (in_addr),
      .in_wdata    (in_wdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_addr    (out_addr),
      .out_wdata   (out_wdata),
      .count       (count),
      .event_total (event_total),
      .end_seen    (end_seen),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_wen   = 1'b0;
      in_addr  = 5'd0;
      in_pc    = 32'h0;
      in_wdata = 32'h0;
   endtask

   task automatic push(input logic [31:0] pc, input logic [4:0] addr, input logic [31:0] wdata);
      in_wen   = 1'b1;
      in_pc    = pc;
      in_addr  = addr;
      in_wdata = wdata;
      tick();
      idle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      idle();
      out_ready = 1'b0;
      reset     = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_valid",    32'(out_valid),  32'd0);
      check("rst_count",    32'(count),      32'd0);
      check("rst_total",    event_total,     32'd0);
      check("rst_end",      32'(end_seen),   32'd0);
      check("rst_ovf",      32'(overflow),   32'd0);
      check("rst_wdata",    out_wdata,       32'd0);

      // r0 and wen filter
      in_wen = 1'b1; in_addr = 5'd0; in_pc = 32'h20; in_wdata = 32'hdead;
      tick();
      in_wen = 1'b0; in_addr = 5'd7;
      tick();
      idle();
      check("flt_count", 32'(count),     32'd0);
      check("flt_valid", 32'(out_valid), 32'd0);
      check("flt_total", event_total,    32'd0);

      // Single event, no pass-through latency beyond one edge
      push(32'h10, 5'd5, 32'h1234);
      check("one_valid", 32'(out_valid), 32'd1);
      check("one_pc",    out_pc,         32'h10);
      check("one_addr",  32'(out_addr),  32'd5);
      check("one_wdata", out_wdata,      32'h1234);
      check("one_count", 32'(count),     32'd1);
      check("one_total", event_total,    32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("one_popped", 32'(count), 32'd0);

      // Fill, overflow, drain, wrap
      for (int i = 1; i <= 8; i++) push(32'h200 + 32'(i), 5'd3, 32'(i));
      check("fill_count", 32'(count), 32'd8);
      push(32'h209, 5'd3, 32'd9);
      check("drop_ovf",   32'(overflow), 32'd1);
      check("drop_count", 32'(count),    32'd8);
      check("drop_total", event_total,   32'd9);
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("drain_%0d", i), out_wdata, 32'(i));
         tick();
      end
      check("drain_valid", 32'(out_valid), 32'd0);
      check("drain_wdata", out_wdata,      32'd0);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(32'h300, 5'd4, 32'h31 + 32'(i));
      check("wrap_count", 32'(count), 32'd3);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("wrap_%0d", i), out_wdata, 32'h31 + 32'(i));
         tick();
      end
      check("wrap_empty", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // Full FIFO with simultaneous push and pop
      do_reset();
      for (int i = 0; i < 8; i++) push(32'h400, 5'd6, 32'h41 + 32'(i));
      out_ready = 1'b1;
      push(32'h408, 5'd6, 32'hAA);
      check("fpp_count", 32'(count),    32'd8);
      check("fpp_ovf",   32'(overflow), 32'd0);
      for (int i = 0; i < 7; i++) begin
         check($sformatf("fpp_%0d", i), out_wdata, 32'h42 + 32'(i));
         tick();
      end
      check("fpp_eighth", out_wdata, 32'hAA);
      tick();
      check("fpp_empty", 32'(count), 32'd0);
      out_ready = 1'b0;

      // End detection
      check("end_pre", 32'(end_seen), 32'd0);
      push(32'ha0, 5'd2, 32'h55);
      check("end_flag",  32'(end_seen), 32'd1);
      check("end_queued", out_wdata,    32'h55);
      check("end_count", 32'(count),    32'd1);
      push(32'hb0, 5'd3, 32'h66);
      check("end_block", 32'(count),    32'd1);
      check("end_total", event_total,   32'd10);

      // Reset mid-operation with both flags set and 4 entries queued
      do_reset();
      for (int i = 0; i < 9; i++) push(32'h500, 5'd8, 32'h61 + 32'(i));
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      out_ready = 1'b0;
      in_pc = 32'ha0;
      tick();
      idle();
      check("mid_count", 32'(count),    32'd4);
      check("mid_flags", {30'd0, overflow, end_seen}, 32'd3);
      check("mid_head",  out_wdata,     32'h65);
      do_reset();
      check("mr_valid", 32'(out_valid), 32'd0);
      check("mr_pc",    out_pc,         32'd0);
      check("mr_addr",  32'(out_addr),  32'd0);
      check("mr_wdata", out_wdata,      32'd0);
      check("mr_count", 32'(count),     32'd0);
      check("mr_total", event_total,    32'd0);
      check("mr_flags", {30'd0, overflow, end_seen}, 32'd0);
      push(32'h600, 5'd9, 32'h77);
      check("mr_new_valid", 32'(out_valid), 32'd1);
      check("mr_new_addr",  32'(out_addr),  32'd9);
      check("mr_new_wdata", out_wdata,      32'h77);
      check("mr_new_total", event_total,    32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
